// File: rtl/playfield_pixel_gen.sv
// Playfield pixel source: 10x20 board RAM, board frame and
// palette lookup, 2-cycle coordinate-to-pixel pipeline.
module playfield_pixel_gen #(
   parameter int BOARD_X0 = 280,
   parameter int BOARD_Y0 = 60,
   parameter int CELL_PX  = 24,
   parameter int COLS     = 10,
   parameter int ROWS     = 20,
   parameter int FRAME_PX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       in_view,
   input  logic       wr_en,
   input  logic [4:0] wr_row,
   input  logic [3:0] wr_col,
   input  logic [2:0] wr_color,
   input  logic       clear_req,
   output logic       wr_ready,
   output logic       clear_busy,
   output logic [7:0] Pixel_Bus,
   output logic       Pixel_Bus_Enable
);

   localparam int         CELLS = COLS * ROWS;
   localparam logic [9:0] CX0 = 10'(BOARD_X0);
   localparam logic [9:0] CX1 = 10'(BOARD_X0 + CELL_PX * COLS);
   localparam logic [9:0] CY0 = 10'(BOARD_Y0);
   localparam logic [9:0] CY1 = 10'(BOARD_Y0 + CELL_PX * ROWS);
   localparam logic [9:0] FX0 = 10'(BOARD_X0 - FRAME_PX);
   localparam logic [9:0] FX1 = 10'(BOARD_X0 + CELL_PX * COLS + FRAME_PX);
   localparam logic [9:0] FY0 = 10'(BOARD_Y0 - FRAME_PX);
   localparam logic [9:0] FY1 = 10'(BOARD_Y0 + CELL_PX * ROWS + FRAME_PX);
   localparam logic [4:0] SUB_LAST = 5'(CELL_PX - 1);

   typedef enum logic {IDLE, CLEAR} state_t;
   typedef enum logic [1:0] {PX_OUT, PX_FRAME, PX_CELL} px_class_t;

   state_t     state;
   logic [7:0] clr_cnt;

   logic [2:0] mem [CELLS];
   logic [2:0] rd_data;
   logic [7:0] wr_addr;
   logic       wr_hit;

   logic [3:0] col, col_n;
   logic [4:0] subx, subx_n;
   logic [4:0] row, row_n;
   logic [4:0] suby, suby_n;
   logic [8:0] rd_addr;

   logic       x_cell, y_cell, x_frame, y_frame;
   px_class_t  cls, cls_q;
   logic       gap_q;
   logic       view_q;
   logic [5:0] rgb;

   function automatic logic [5:0] palette(input logic [2:0] idx);
      logic [5:0] c;
      c = 6'b000000;
      unique case (idx)
         3'd0: c = 6'b000001;
         3'd1: c = 6'b001111;
         3'd2: c = 6'b111100;
         3'd3: c = 6'b110011;
         3'd4: c = 6'b001100;
         3'd5: c = 6'b110000;
         3'd6: c = 6'b000011;
         3'd7: c = 6'b111000;
         default: c = 6'b000000;
      endcase
      return c;
   endfunction

   assign wr_ready = ~clear_busy;
   assign wr_addr  = 8'(wr_row) * 8'(COLS) + 8'(wr_col);
   assign wr_hit   = wr_en && wr_ready &&
                     (wr_row < 5'(ROWS)) && (wr_col < 4'(COLS));

   // Clear sequencer: walks every cell address, restartable by clear_req
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         clr_cnt    <= 8'd0;
         clear_busy <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (clear_req) begin
                  state      <= CLEAR;
                  clr_cnt    <= 8'd0;
                  clear_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (clear_req) begin
                  clr_cnt <= 8'd0;
               end else if (clr_cnt == 8'(CELLS - 1)) begin
                  state      <= IDLE;
                  clear_busy <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Cell RAM: clear has priority; read returns pre-write contents
   always_ff @(posedge clk) begin
      if (clear_busy) begin
         mem[clr_cnt] <= 3'd0;
      end else if (wr_hit) begin
         mem[wr_addr] <= wr_color;
      end
      rd_data <= (rd_addr < 9'(CELLS)) ? mem[rd_addr[7:0]] : 3'd0;
   end

   // Next tracker values for the current coordinate (no dividers)
   always_comb begin
      col_n  = col;
      subx_n = subx;
      row_n  = row;
      suby_n = suby;
      if (in_view) begin
         if (pixel_x == CX0) begin
            col_n  = 4'd0;
            subx_n = 5'd0;
         end else if (subx == SUB_LAST) begin
            col_n  = col + 4'd1;
            subx_n = 5'd0;
         end else begin
            subx_n = subx + 5'd1;
         end
         if (pixel_x == 10'd0) begin
            if (pixel_y == CY0) begin
               row_n  = 5'd0;
               suby_n = 5'd0;
            end else if (y_cell) begin
               if (suby == SUB_LAST) begin
                  row_n  = row + 5'd1;
                  suby_n = 5'd0;
               end else begin
                  suby_n = suby + 5'd1;
               end
            end
         end
      end
   end

   assign rd_addr = 9'(row_n) * 9'(COLS) + 9'(col_n);

   // Coordinate classification against cell area and frame box
   always_comb begin
      x_cell  = (pixel_x >= CX0) && (pixel_x < CX1);
      y_cell  = (pixel_y >= CY0) && (pixel_y < CY1);
      x_frame = (pixel_x >= FX0) && (pixel_x < FX1);
      y_frame = (pixel_y >= FY0) && (pixel_y < FY1);
      cls     = PX_OUT;
      if (x_cell && y_cell) begin
         cls = PX_CELL;
      end else if (x_frame && y_frame) begin
         cls = PX_FRAME;
      end
   end

   // Tracker state and stage 1 registers
   always_ff @(posedge clk) begin
      if (rst) begin
         col    <= 4'd0;
         subx   <= 5'd0;
         row    <= 5'd0;
         suby   <= 5'd0;
         cls_q  <= PX_OUT;
         gap_q  <= 1'b0;
         view_q <= 1'b0;
      end else begin
         col    <= col_n;
         subx   <= subx_n;
         row    <= row_n;
         suby   <= suby_n;
         cls_q  <= cls;
         gap_q  <= (subx_n == SUB_LAST) || (suby_n == SUB_LAST);
         view_q <= in_view;
      end
   end

   // Colour selection from class, gap flag and cell data
   always_comb begin
      rgb = 6'b000000;
      unique case (cls_q)
         PX_CELL: begin
            if (gap_q && (rd_data != 3'd0)) begin
               rgb = 6'b000000;
            end else begin
               rgb = palette(rd_data);
            end
         end
         PX_FRAME: rgb = 6'b111111;
         default:  rgb = 6'b000000;
      endcase
   end

   // Stage 2: output register, blanked outside the viewable area
   always_ff @(posedge clk) begin
      if (rst) begin
         Pixel_Bus        <= 8'd0;
         Pixel_Bus_Enable <= 1'b0;
      end else begin
         Pixel_Bus        <= view_q ? {2'b00, rgb} : 8'd0;
         Pixel_Bus_Enable <= view_q;
      end
   end

endmodule

// File: tb/tb_playfield_pixel_gen.sv
// Bench for playfield_pixel_gen: arithmetic board/pixel model,
// countdown model of the clear sequence, randomized writes.
module tb_playfield_pixel_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic       in_view = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_row = '0;
   logic [3:0] wr_col = '0;
   logic [2:0] wr_color = '0;
   logic       clear_req = 1'b0;
   logic       wr_ready;
   logic       clear_busy;
   logic [7:0] Pixel_Bus;
   logic       Pixel_Bus_Enable;

   playfield_pixel_gen dut (
      .clk              (clk),
      .rst              (rst),
      .pixel_x          (pixel_x),
      .pixel_y          (pixel_y),
      .in_view          (in_view),
      .wr_en            (wr_en),
      .wr_row           (wr_row),
      .wr_col           (wr_col),
      .wr_color         (wr_color),
      .clear_req        (clear_req),
      .wr_ready         (wr_ready),
      .clear_busy       (clear_busy),
      .Pixel_Bus        (Pixel_Bus),
      .Pixel_Bus_Enable (Pixel_Bus_Enable)
   );

   always #10 clk = ~clk;

   int    errors = 0;
   int    checks = 0;
   string tag = "";

   // model state: board contents and remaining busy cycles
   int board [200];
   int m_rem = 0;
   bit [5:0] pal [8] = '{6'b000001, 6'b001111, 6'b111100, 6'b110011,
                         6'b001100, 6'b110000, 6'b000011, 6'b111000};

   // expected output for the sample just taken / for the next one
   logic [7:0] e_pb = '0, q_pb = '0;
   logic       e_en = 1'b0, q_en = 1'b0;
   logic       e_chk = 1'b0, q_chk = 1'b0;

   function automatic void exp_pix(input int x, input int y,
                                   input logic v,
                                   output logic [7:0] pb,
                                   output logic en);
      int c, r, sx, sy, d;
      en = v;
      pb = 8'h00;
      if (!v) return;
      if (x >= 280 && x < 520 && y >= 60 && y < 540) begin
         c  = (x - 280) / 24;
         sx = (x - 280) % 24;
         r  = (y - 60) / 24;
         sy = (y - 60) % 24;
         d  = board[r * 10 + c];
         if ((sx == 23 || sy == 23) && d != 0) pb = 8'h00;
         else pb = {2'b00, pal[d]};
      end else if (x >= 276 && x < 524 && y >= 56 && y < 544) begin
         pb = 8'h3F;
      end
   endfunction

   task automatic step(input int x, input int y, input logic v);
      logic [7:0] c_pb;
      logic       c_en;
      int         pre_rem;
      logic       acc;
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      in_view = v;
      exp_pix(x, y, v, c_pb, c_en);
      pre_rem = m_rem;
      acc = wr_en && !rst && m_rem == 0 && wr_row < 20 && wr_col < 10;
      @(posedge clk);
      #1;
      if (acc) board[wr_row * 10 + wr_col] = int'(wr_color);
      if (rst || clear_req) begin
         m_rem = 200;
         foreach (board[i]) board[i] = 0;
      end else if (m_rem > 0) begin
         m_rem--;
      end
      if (rst) begin
         e_pb = 8'h00; e_en = 1'b0; e_chk = 1'b1;
         q_pb = 8'h00; q_en = 1'b0; q_chk = 1'b1;
      end else begin
         e_pb = q_pb; e_en = q_en; e_chk = q_chk;
         q_pb = c_pb; q_en = c_en; q_chk = (pre_rem == 0);
      end
   endtask

   task automatic scan_board(input logic [23:0] mask [20]);
      int xs[$], ys[$];
      for (int y = 60; y < 540; y++) begin
         xs.push_back(0);
         ys.push_back(y);
         if (mask[(y - 60) / 24][(y - 60) % 24]) begin
            for (int x = 276; x < 524; x++) begin
               xs.push_back(x);
               ys.push_back(y);
            end
         end
      end
      for (int i = 0; i < xs.size() + 2; i++) begin
         if (i < xs.size()) step(xs[i], ys[i], 1'b1);
         else step(0, 0, 1'b0);
         if (e_chk) begin
            checks++;
            if (Pixel_Bus !== e_pb || Pixel_Bus_Enable !== e_en) begin
               errors++;
               $display("FAIL %s pix t=%0t got=%h/%b exp=%h/%b",
                        tag, $time, Pixel_Bus, Pixel_Bus_Enable,
                        e_pb, e_en);
            end
         end
      end
   endtask

   task automatic test_reset();
      int n;
      tag = "reset";
      rst = 1'b1;
      step(0, 0, 1'b0);
      rst = 1'b0;
      checks += 4;
      if (Pixel_Bus !== 8'h00) begin
         errors++;
         $display("FAIL reset_pb got=%h exp=00", Pixel_Bus);
      end
      if (Pixel_Bus_Enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_en got=%b exp=0", Pixel_Bus_Enable);
      end
      if (clear_busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy got=%b exp=1", clear_busy);
      end
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=0", wr_ready);
      end
      n = 1;
      for (int i = 0; i < 400; i++) begin
         step(0, 0, 1'b0);
         checks += 2;
         if (clear_busy !== (m_rem > 0)) begin
            errors++;
            $display("FAIL reset_busy_win got=%b exp=%b",
                     clear_busy, m_rem > 0);
         end
         if (wr_ready !== (m_rem == 0)) begin
            errors++;
            $display("FAIL reset_ready_win got=%b exp=%b",
                     wr_ready, m_rem == 0);
         end
         if (clear_busy !== 1'b1) break;
         n++;
      end
      checks++;
      if (n != 200) begin
         errors++;
         $display("FAIL reset_busy_len got=%0d exp=200", n);
      end
   endtask

   task automatic test_clear_board();
      logic [23:0] m [20];
      tag = "clear_board";
      foreach (m[r]) m[r] = 24'(1) << $urandom_range(0, 23);
      m[0] = m[0] | 24'h800000;
      scan_board(m);
   endtask

   task automatic test_single_write();
      int xs[$];
      tag = "single_write";
      wr_row = 5'd0; wr_col = 4'd0; wr_color = 3'd1;
      wr_en = 1'b1;
      step(0, 0, 1'b0);
      wr_en = 1'b0;
      xs.push_back(0);
      for (int x = 280; x <= 303; x++) xs.push_back(x);
      for (int i = 0; i < xs.size() + 2; i++) begin
         if (i < xs.size()) step(xs[i], 60, 1'b1);
         else step(0, 0, 1'b0);
         if (e_chk) begin
            checks++;
            if (Pixel_Bus !== e_pb || Pixel_Bus_Enable !== e_en) begin
               errors++;
               $display("FAIL %s pix t=%0t got=%h/%b exp=%h/%b",
                        tag, $time, Pixel_Bus, Pixel_Bus_Enable,
                        e_pb, e_en);
            end
         end
      end
   endtask

   task automatic test_corner();
      logic [23:0] m [20];
      tag = "corner";
      wr_row = 5'd19; wr_col = 4'd9; wr_color = 3'd5;
      wr_en = 1'b1;
      step(0, 0, 1'b0);
      wr_en = 1'b0;
      foreach (m[r]) m[r] = 24'd0;
      m[19] = (24'(1) << 4) | (24'(1) << 23);
      scan_board(m);
   endtask

   task automatic test_frame();
      int xs[6] = '{276, 523, 400, 400, 275, 524};
      int ys[6] = '{300, 300, 56, 543, 300, 300};
      tag = "frame";
      for (int i = 0; i < 8; i++) begin
         if (i < 6) step(xs[i], ys[i], 1'b1);
         else step(0, 0, 1'b0);
         if (e_chk) begin
            checks++;
            if (Pixel_Bus !== e_pb || Pixel_Bus_Enable !== e_en) begin
               errors++;
               $display("FAIL %s pix t=%0t got=%h/%b exp=%h/%b",
                        tag, $time, Pixel_Bus, Pixel_Bus_Enable,
                        e_pb, e_en);
            end
         end
      end
   endtask

   task automatic test_random_board();
      logic [23:0] m [20];
      tag = "random_board";
      for (int i = 0; i < 60; i++) begin
         wr_row   = 5'($urandom_range(0, 22));
         wr_col   = 4'($urandom_range(0, 12));
         wr_color = 3'($urandom_range(0, 7));
         wr_en    = 1'b1;
         step(0, 0, 1'b0);
         wr_en = 1'b0;
      end
      foreach (m[r]) begin
         if (r % 3 == 0) m[r] = 24'h800000;
         else m[r] = 24'(1) << $urandom_range(0, 23);
      end
      scan_board(m);
   endtask

   task automatic test_clear_req();
      logic [23:0] m [20];
      int  n;
      logic again;
      tag = "clear_req";
      again = 1'b0;
      wr_color = 3'd3;
      wr_row = 5'($urandom_range(0, 19));
      wr_col = 4'($urandom_range(0, 9));
      wr_en = 1'b1;
      clear_req = 1'b1;
      step(0, 0, 1'b0);
      clear_req = 1'b0;
      n = 1;
      for (int i = 0; i < 600; i++) begin
         if (n == 50 && !again) begin
            clear_req = 1'b1;
            again = 1'b1;
         end
         wr_row = 5'($urandom_range(0, 19));
         wr_col = 4'($urandom_range(0, 9));
         step(0, 0, 1'b0);
         clear_req = 1'b0;
         checks += 2;
         if (clear_busy !== (m_rem > 0)) begin
            errors++;
            $display("FAIL clear_busy_win got=%b exp=%b",
                     clear_busy, m_rem > 0);
         end
         if (wr_ready !== (m_rem == 0)) begin
            errors++;
            $display("FAIL clear_ready_win got=%b exp=%b",
                     wr_ready, m_rem == 0);
         end
         if (clear_busy !== 1'b1) break;
         n++;
      end
      wr_en = 1'b0;
      checks++;
      if (n != 250) begin
         errors++;
         $display("FAIL clear_busy_len got=%0d exp=250", n);
      end
      foreach (m[r]) m[r] = 24'(1) << $urandom_range(0, 23);
      m[19] = m[19] | 24'h800000;
      scan_board(m);
   endtask

   task automatic test_view_sweep();
      logic vs[$];
      tag = "view_sweep";
      for (int i = 0; i < 5; i++) vs.push_back(1'b0);
      for (int i = 0; i < 8; i++) vs.push_back(1'b1);
      for (int i = 0; i < 5; i++) vs.push_back(1'b0);
      for (int i = 0; i < 24; i++) vs.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < vs.size() + 2; i++) begin
         if (i < vs.size()) step(277, 300, vs[i]);
         else step(0, 0, 1'b0);
         if (e_chk) begin
            checks++;
            if (Pixel_Bus !== e_pb || Pixel_Bus_Enable !== e_en) begin
               errors++;
               $display("FAIL %s pix t=%0t got=%h/%b exp=%h/%b",
                        tag, $time, Pixel_Bus, Pixel_Bus_Enable,
                        e_pb, e_en);
            end
         end
         if (Pixel_Bus_Enable === 1'b0) begin
            checks++;
            if (Pixel_Bus !== 8'h00) begin
               errors++;
               $display("FAIL view_blank got=%h exp=00", Pixel_Bus);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_board();
      test_single_write();
      test_corner();
      test_frame();
      test_random_board();
      test_clear_req();
      test_view_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
